// File: rtl/ldpc_pkg.sv
// Shared definitions for the serial LDPC check-node unit:
// min-sum rule encodings, default LLR width, FSM state type.
package ldpc_pkg;

   localparam int LLR_WIDTH_DEF = 8;

   localparam int MS_PLAIN  = 0;
   localparam int MS_OFFSET = 1;
   localparam int MS_NORM   = 2;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      EMIT
   } cnu_state_e;

endpackage

// File: rtl/ldpc_mag_adj.sv
// Combinational min-sum magnitude adjustment:
// plain, offset (saturating at 0) or normalized by 3/4.
module ldpc_mag_adj
   import ldpc_pkg::*;
#(
   parameter int LLR_WIDTH = LLR_WIDTH_DEF,
   parameter int MODE      = MS_PLAIN,
   parameter int OFFSET    = 1,
   localparam int MW       = LLR_WIDTH - 1
) (
   input  logic [MW-1:0] mag,
   output logic [MW-1:0] adj
);

   always_comb begin
      adj = mag;
      case (MODE)
         MS_OFFSET:
            adj = ({1'b0, mag} > (MW+1)'(OFFSET))
                ? MW'({1'b0, mag} - (MW+1)'(OFFSET))
                : '0;
         MS_NORM:
            adj = MW'(({2'b00, mag} + {1'b0, mag, 1'b0}) >> 2);
         default:
            adj = mag;
      endcase
   end

endmodule

// File: rtl/ldpc_cnu_serial.sv
// Serial min-sum check-node unit: accumulates one frame of LLRs,
// then emits one extrinsic check-to-variable message per position.
module ldpc_cnu_serial
   import ldpc_pkg::*;
#(
   parameter int LLR_WIDTH  = LLR_WIDTH_DEF,
   parameter int ROW_WEIGHT = 24,
   parameter int MODE       = MS_PLAIN,
   parameter int OFFSET     = 1,
   localparam int MW        = LLR_WIDTH - 1,
   localparam int IW        = $clog2(ROW_WEIGHT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LLR_WIDTH-1:0] in_llr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LLR_WIDTH-1:0] out_llr,
   output logic [IW-1:0]        out_idx,
   output logic                 out_last,
   output logic [MW-1:0]        min,
   output logic [MW-1:0]        submin,
   output logic [IW-1:0]        min_idx,
   output logic                 frame_done
);

   localparam logic [IW-1:0] LAST_IDX = IW'(ROW_WEIGHT - 1);

   cnu_state_e            state;
   logic [IW-1:0]         in_cnt;
   logic [ROW_WEIGHT-1:0] sign_reg;
   logic                  sign_prod;
   logic [MW-1:0]         in_mag;
   logic                  in_sgn;
   logic [MW-1:0]         sel_mag;
   logic [MW-1:0]         adj_mag;
   logic                  out_sgn;

   assign in_mag = in_llr[MW-1:0];
   assign in_sgn = in_llr[MW];

   // Extrinsic rule: the min position sees the second minimum.
   assign sel_mag  = (out_idx == min_idx) ? submin : min;
   assign out_sgn  = (sign_prod ^ sign_reg[out_idx]) & (|adj_mag);
   assign out_llr  = out_valid ? {out_sgn, adj_mag} : '0;
   assign out_last = out_valid & (out_idx == LAST_IDX);

   ldpc_mag_adj #(
      .LLR_WIDTH (LLR_WIDTH),
      .MODE      (MODE),
      .OFFSET    (OFFSET)
   ) u_mag_adj (
      .mag (sel_mag),
      .adj (adj_mag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         in_cnt     <= '0;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_idx    <= '0;
         frame_done <= 1'b0;
         min        <= '0;
         submin     <= '0;
         min_idx    <= '0;
         sign_reg   <= '0;
         sign_prod  <= 1'b0;
      end else if (en) begin
         frame_done <= 1'b0;
         unique case (state)
            IDLE, ACCUM: begin
               if (in_valid) begin
                  in_cnt           <= in_cnt + 1'b1;
                  sign_reg[in_cnt] <= in_sgn;
                  if (state == IDLE) begin
                     state     <= ACCUM;
                     min       <= in_mag;
                     min_idx   <= '0;
                     submin    <= '1;
                     sign_prod <= in_sgn;
                  end else begin
                     sign_prod <= sign_prod ^ in_sgn;
                     if (in_mag < min) begin
                        submin  <= min;
                        min     <= in_mag;
                        min_idx <= in_cnt;
                     end else if (in_mag < submin) begin
                        submin <= in_mag;
                     end
                  end
                  if (in_cnt == LAST_IDX) begin
                     state     <= EMIT;
                     in_cnt    <= '0;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_idx   <= '0;
                  end
               end
            end
            EMIT: begin
               if (out_ready) begin
                  if (out_idx == LAST_IDX) begin
                     state      <= IDLE;
                     in_ready   <= 1'b1;
                     out_valid  <= 1'b0;
                     out_idx    <= '0;
                     frame_done <= 1'b1;
                  end else begin
                     out_idx <= out_idx + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
